// File: rtl/add_pipe_nbits.sv
// add_pipe_nbits: pipelined WIDTH-bit ripple adder split into STAGES
// carry-registered segments, with a valid/ready handshake on both sides.
//
// Optional feature: define ADD_PIPE_SUB_EN to add the i_sub port
// (A - B computed as A + ~B + 1; o_carry=1 means no borrow).
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_valid     upstream operands valid
//   o_ready     block accepts operands this cycle (combinational ready chain)
//   i_data_one  operand A
//   i_data_two  operand B
//   i_carry     carry-in to bit 0
//   i_sub       subtract select (only with ADD_PIPE_SUB_EN)
//   o_valid     result valid
//   i_ready     downstream accepts result
//   o_data      (A + B + cin) mod 2^WIDTH
//   o_carry     carry-out of bit WIDTH-1
module add_pipe_nbits #(
    parameter int unsigned WIDTH  = 30,
    parameter int unsigned STAGES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_one,
    input  logic [WIDTH-1:0] i_data_two,
    input  logic             i_carry,
`ifdef ADD_PIPE_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry
);

    localparam int W    = int'(WIDTH);
    localparam int NSTG = int'(STAGES);
    localparam int SEG  = (W + NSTG - 1) / NSTG;

    // Operand B and carry as seen by stage 0; subtraction is folded in here
    // so the rest of the pipeline is a plain adder.
    logic [WIDTH-1:0] b_ent;
    logic             c_ent;

`ifdef ADD_PIPE_SUB_EN
    always_comb begin
        b_ent = i_sub ? ~i_data_two : i_data_two;
        c_ent = i_sub | i_carry;
    end
`else
    assign b_ent = i_data_two;
    assign c_ent = i_carry;
`endif

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        // Bit range [LO, HI) added by this stage; may be empty when
        // STAGES does not divide WIDTH evenly.
        localparam int LO = k * SEG;
        localparam int HI = ((k + 1) * SEG < W) ? (k + 1) * SEG : W;

        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [WIDTH-1:0] s_d;
        logic             c_d;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             vld_q;
        logic             load;

        // Stage inputs: ports for stage 0, skew registers of the stage below otherwise.
        if (k == 0) begin : g_src
            assign a_in = i_data_one;
            assign b_in = b_ent;
            assign s_in = '0;
            assign c_in = c_ent;
            assign v_in = i_valid;
        end else begin : g_src
            assign a_in = g_stg[k-1].g_hold.a_q;
            assign b_in = g_stg[k-1].g_hold.b_q;
            assign s_in = g_stg[k-1].s_q;
            assign c_in = g_stg[k-1].c_q;
            assign v_in = g_stg[k-1].vld_q;
        end

        // Load when empty or when the stage above is taking our contents.
        if (k == NSTG - 1) begin : g_load
            assign load = !vld_q | i_ready;
        end else begin : g_load
            assign load = !vld_q | g_stg[k+1].load;
        end

        // Full-adder ripple over this stage's segment; other bits pass through.
        always_comb begin
            s_d = s_in;
            c_d = c_in;
            for (int i = 0; i < W; i++) begin
                if (i >= LO && i < HI) begin
                    s_d[i] = a_in[i] ^ b_in[i] ^ c_d;
                    c_d    = (a_in[i] & b_in[i]) | (c_d & (a_in[i] ^ b_in[i]));
                end
            end
        end

        // Valid flag follows every load; data only captured for real operations
        // so outputs stay zero until the first result.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                vld_q <= 1'b0;
                s_q   <= '0;
                c_q   <= 1'b0;
            end else if (load) begin
                vld_q <= v_in;
                if (v_in) begin
                    s_q <= s_d;
                    c_q <= c_d;
                end
            end
        end

        // Operand skew registers, not needed after the last stage.
        if (k < NSTG - 1) begin : g_hold
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load && v_in) begin
                    a_q <= a_in;
                    b_q <= b_in;
                end
            end
        end
    end

    assign o_ready = g_stg[0].load;
    assign o_valid = g_stg[NSTG-1].vld_q;
    assign o_data  = g_stg[NSTG-1].s_q;
    assign o_carry = g_stg[NSTG-1].c_q;

endmodule

// File: tb/tb_add_pipe_nbits.sv
// tb_add_pipe_nbits: randomized and directed self-checking bench for
// add_pipe_nbits against a queue-based arithmetic reference model.
module tb_add_pipe_nbits;

    localparam int unsigned WIDTH  = 30;
    localparam int unsigned STAGES = 3;
    localparam int unsigned WP1    = WIDTH + 1;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data_one;
    logic [WIDTH-1:0] i_data_two;
    logic             i_carry;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_carry;

    add_pipe_nbits #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data_one (i_data_one),
        .i_data_two (i_data_two),
        .i_carry    (i_carry),
`ifdef ADD_PIPE_SUB_EN
        .i_sub      (i_sub),
`endif
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_carry    (o_carry)
    );

    typedef struct {
        logic [WIDTH:0] exp;
        int             acc;
    } exp_t;

    exp_t           q[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    bit             lat_chk = 0;
    bit             hold_prev = 0;
    logic [WIDTH:0] prev_out;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference: {carry, sum} of the unsigned WIDTH-bit add (or subtract).
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
        longint unsigned s;
        if (sub) s = 64'(a) + ((64'(1) << WIDTH) - 64'(1) - 64'(b)) + 64'(1);
        else     s = 64'(a) + 64'(b) + 64'(cin);
        return WP1'(s);
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: evaluated mid low-phase, after inputs for the next edge settle.
    always @(negedge i_clk) begin
        exp_t e;
        #2;
        if (!i_rst_n) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 64'(o_valid), 64'(1));
                check("hold_data", 64'({o_carry, o_data}), 64'(prev_out));
            end
            if (o_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 64'(o_valid), 64'(0));
                end else if (i_ready) begin
                    e = q.pop_front();
                    check("result", 64'({o_carry, o_data}), 64'(e.exp));
                    if (lat_chk) check("latency", 64'(cyc - e.acc), 64'(STAGES));
                end
            end
            if (lat_chk) check("stream_ready", 64'(o_ready), 64'(1));
            if (i_valid && o_ready) begin
                e.exp = model(i_data_one, i_data_two, i_carry, i_sub);
                e.acc = cyc;
                q.push_back(e);
            end
            hold_prev = o_valid && !i_ready;
            prev_out  = {o_carry, o_data};
        end
    end

    // Hold one operation on the inputs until accepted (called at a falling edge).
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic s);
        bit done = 0;
        i_valid    = 1'b1;
        i_data_one = a;
        i_data_two = b;
        i_carry    = c;
        i_sub      = s;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            done = o_ready;
            @(negedge i_clk);
        end
        if (!done) check("send_timeout", 64'(0), 64'(1));
        i_valid = 1'b0;
        i_sub   = 1'b0;
    endtask

    // Returns 1 time unit after the falling edge where o_valid is seen.
    task automatic wait_valid(input string name);
        bit seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge i_clk);
            #1;
            seen = o_valid;
        end
        if (!seen) check(name, 64'(0), 64'(1));
    endtask

    initial begin
        int accepted;
        i_clk      = 1'b0;
        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_data_one = '0;
        i_data_two = '0;
        i_carry    = 1'b0;
        i_sub      = 1'b0;
        i_ready    = 1'b1;

        // Reset then idle
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_data", 64'(o_data), 64'(0));
        check("rst_carry", 64'(o_carry), 64'(0));
        check("rst_ready", 64'(o_ready), 64'(1));

        // Pin the model with hand-computed values
        check("model_add", 64'(model(30'h3FFFFFFF, 30'h1, 1'b0, 1'b0)), 64'h4000_0000);
        check("model_sub_borrow", 64'(model(30'd5, 30'd7, 1'b0, 1'b1)), 64'h3FFF_FFFE);
        check("model_sub_ok", 64'(model(30'd7, 30'd5, 1'b1, 1'b1)), 64'h4000_0002);

        // Single op: carry crosses both segment boundaries, latency exactly 3
        @(negedge i_clk);
        i_valid    = 1'b1;
        i_data_one = 30'h3FFFFFFF;
        i_data_two = 30'h00000001;
        i_carry    = 1'b0;
        #1;
        check("single_ready", 64'(o_ready), 64'(1));
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        #1;
        check("single_early", 64'(o_valid), 64'(0));
        @(negedge i_clk);
        #1;
        check("single_valid", 64'(o_valid), 64'(1));
        check("single_data", 64'(o_data), 64'(0));
        check("single_carry", 64'(o_carry), 64'(1));

        // Stream: 8 back-to-back ops at full throughput
        @(negedge i_clk);
        lat_chk = 1;
        for (int i = 0; i < 8; i++) begin
            i_valid    = 1'b1;
            i_data_one = WIDTH'(i * 32'h01000001);
            i_data_two = 30'h00FFFFFF;
            i_carry    = 1'(i);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        repeat (6) @(negedge i_clk);
        lat_chk = 0;
        check("stream_drained", 64'(q.size()), 64'(0));

        // Backpressure: fill with i_ready low, then drain in order
        i_ready  = 1'b0;
        accepted = 0;
        for (int n = 0; n < 10; n++) begin
            i_valid    = 1'b1;
            i_data_one = WIDTH'(accepted * 32'h0123457 + 32'h3FF00000);
            i_data_two = WIDTH'(accepted * 32'h0765433 + 32'h000FFFFF);
            i_carry    = 1'(accepted);
            #1;
            if (o_ready) accepted++;
            @(negedge i_clk);
        end
        #1;
        check("bp_accepted", 64'(accepted), 64'(STAGES));
        check("bp_ready_low", 64'(o_ready), 64'(0));
        check("bp_valid", 64'(o_valid), 64'(1));
        @(negedge i_clk);
        i_ready = 1'b1;
        while (accepted < 5) begin
            send(WIDTH'(accepted * 32'h0123457 + 32'h3FF00000),
                 WIDTH'(accepted * 32'h0765433 + 32'h000FFFFF), 1'(accepted), 1'b0);
            accepted++;
        end
        repeat (6) @(negedge i_clk);
        check("bp_drained", 64'(q.size()), 64'(0));

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            i_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       i_data_one = '1;
                1:       i_data_one = '0;
                default: i_data_one = WIDTH'($urandom);
            endcase
            i_data_two = ($urandom_range(0, 3) == 0) ? '1 : WIDTH'($urandom);
            i_carry    = 1'($urandom_range(0, 1));
`ifdef ADD_PIPE_SUB_EN
            i_sub      = 1'($urandom_range(0, 1));
`endif
            i_ready    = ($urandom_range(0, 3) != 0);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_sub   = 1'b0;
        i_ready = 1'b1;
        repeat (8) @(negedge i_clk);
        check("rand_drained", 64'(q.size()), 64'(0));

`ifdef ADD_PIPE_SUB_EN
        // Subtract with and without borrow
        send(30'd5, 30'd7, 1'b0, 1'b1);
        wait_valid("sub1_timeout");
        check("sub1_data", 64'(o_data), 64'h3FFFFFFE);
        check("sub1_carry", 64'(o_carry), 64'(0));
        @(negedge i_clk);
        send(30'd7, 30'd5, 1'b0, 1'b1);
        wait_valid("sub2_timeout");
        check("sub2_data", 64'(o_data), 64'(2));
        check("sub2_carry", 64'(o_carry), 64'(1));
        repeat (4) @(negedge i_clk);
`endif

        // Reset mid-flight: two ops inside, first one presented
        @(negedge i_clk);
        i_ready = 1'b0;
        send(30'h12345678, 30'h0ABCDEF0, 1'b1, 1'b0);
        send(30'h3FFFFFFF, 30'h3FFFFFFF, 1'b1, 1'b0);
        wait_valid("mid_timeout");
        #2;
        i_rst_n = 1'b0;
        q.delete();
        #1;
        check("mid_rst_valid", 64'(o_valid), 64'(0));
        check("mid_rst_data", 64'(o_data), 64'(0));
        check("mid_rst_ready", 64'(o_ready), 64'(1));
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        repeat (10) @(negedge i_clk);
        #1;
        check("post_rst_valid", 64'(o_valid), 64'(0));

        // Pipeline still works after reset
        send(30'h2AAAAAAA, 30'h15555555, 1'b1, 1'b0);
        repeat (6) @(negedge i_clk);
        check("final_drained", 64'(q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/add_pipe_nbits.md
Name: add_pipe_nbits

Overview:
- Parametrised, pipelined successor to the fixed-width ripple adders used in the mantissa/exponent datapath of the floating-point multiplier.
- Splits a WIDTH-bit add into STAGES carry-registered segments. Each segment is built from the existing full_adder ripple structure.
- Carries operand/result skew internally and adds a valid/ready handshake, so the multiplier's partial-product accumulation can stream one operation per cycle at higher clock rates.

Parameters:
- WIDTH, 30, operand and result width in bits; legal range 2..64.
- STAGES, 3, number of pipeline segments; legal range 1..WIDTH. Segment width SEG = ceil(WIDTH/STAGES). The last segment takes the remainder bits.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream operands valid.
- o_ready  output  1  block can accept operands this cycle.
- i_data_one  input  WIDTH  operand A.
- i_data_two  input  WIDTH  operand B.
- i_carry  input  1  carry-in to bit 0.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_data  output  WIDTH  sum A+B+cin, modulo 2^WIDTH.
- o_carry  output  1  carry-out of bit WIDTH-1.

Behaviour:
- Reset (asynchronous, i_rst_n=0): all stage valid flags, skew registers, o_data, o_carry and o_valid clear to 0 immediately. Outputs stay 0 until the first result completes.
- Reset mid-operation discards all in-flight operations. No partial result is ever presented.
- Transfers:
  - Input transfer occurs when i_valid & o_ready at a rising edge.
  - Output transfer occurs when o_valid & i_ready at a rising edge.
- Stage k (0..STAGES-1):
  - Adds segment k of A and B plus the registered carry from stage k-1. Stage 0 uses i_carry.
  - Registers the segment sum, its carry-out, the not-yet-added upper operand segments, and the already-computed lower result segments.
- Stage advance rule:
  - Stage k loads when it is empty or stage k+1 loads.
  - The last stage loads when it is empty or i_ready=1.
  - o_ready = stage 0 load condition.
  - Bubbles collapse: an empty stage always accepts from the stage below, independent of i_ready.
- Latency: exactly STAGES cycles from input transfer to o_valid, with no stalls. Throughput: 1 op/cycle when i_ready is held 1.
- Backpressure: when o_valid=1 and i_ready=0, o_data/o_carry/o_valid hold stable. Upstream stalls only once every stage is occupied.
- Simultaneous output transfer and full pipeline in the same cycle: a new input is accepted (o_ready=1 via the combinational ready chain).
- STAGES=1: a single registered adder, latency 1.
- i_data_* are sampled only on an input transfer; changes while o_ready=0 are ignored.
- Arithmetic is unsigned; o_carry is the true carry-out of the full WIDTH add.
- Ordering is strictly FIFO; no reordering.

Optional Feature:
- Macro ADD_PIPE_SUB_EN.
- Defined:
  - Adds port i_sub (input, 1), sampled with the operands and carried down the pipeline.
  - When i_sub=1, the result is A + ~B + 1 (i_carry ignored, forced to 1). o_carry=1 means no borrow (A>=B).
  - When i_sub=0, the block behaves as the plain adder.
- Undefined: port i_sub is absent and the block always adds.

Test Plan:
- Reset then idle: i_rst_n=0 for 3 cycles, release -> o_valid=0, o_data=0, o_carry=0, o_ready=1.
- Single op (WIDTH=30, STAGES=3): A=0x3FFFFFFF, B=0x00000001, cin=0, accepted at cycle t -> at cycle t+3, o_valid=1, o_data=0x00000000, o_carry=1. This checks the carry crossing both segment boundaries.
- Stream: 8 back-to-back ops A=i*0x01000001, B=0x00FFFFFF, cin=i[0], i_ready=1 -> 8 consecutive valid results, in order, each matching the reference sum; o_ready never deasserts.
- Backpressure: i_ready=0 after the first result, 5 ops offered -> 3 accepted, then o_ready=0. The first result is held stable until i_ready=1, after which the remaining results drain in order with no loss or duplication.
- Reset mid-flight: assert i_rst_n=0 while 2 ops are in flight -> o_valid drops to 0 asynchronously. After release, no stale result ever appears.
- With ADD_PIPE_SUB_EN defined: A=5, B=7, i_sub=1 -> o_data=0x3FFFFFFE, o_carry=0. Then A=7, B=5, i_sub=1 -> o_data=2, o_carry=1.
